// File: rtl/cory_demux2_pkg.sv
// Shared definitions for the cory_demux2 stream demultiplexer.
// Optional per-output accept counters are enabled with CORY_DEMUX2_CNT_EN.
`ifndef CORY_DEMUX2_PKG_SV
`define CORY_DEMUX2_PKG_SV

package cory_demux2_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        SEL_Z0 = 1'b0,
        SEL_Z1 = 1'b1
    } sel_e;

    // Pointer width for a buffer of v entries; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/cory_demux2_buf.sv
// Q-entry synchronous FIFO with registered storage and no fall-through.
// full/empty derive only from the registered count.
module cory_demux2_buf
    import cory_demux2_pkg::*;
#(
    parameter int W = 8,
    parameter int Q = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_d,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_d
);

    localparam int AW = clog2(Q);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [Q];
    logic [W-1:0]  mem_d [Q];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full   = (count_q == CW'(Q));
    assign empty  = (count_q == '0);
    assign head_d = mem_q[rd_ptr_q];

    // Q is a power of two, so the pointers wrap naturally modulo Q.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_d;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Q; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < Q; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/cory_demux2.sv
// Valid/ready 1:2 stream demux with a FIFO per output; data and select join.
// Optional accept counters o_cnt0/o_cnt1 are present when CORY_DEMUX2_CNT_EN is defined.
module cory_demux2
    import cory_demux2_pkg::*;
#(
    parameter int N = 8,
    parameter int Q = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_a_v,
    input  logic [N-1:0]     i_a_d,
    output logic             o_a_r,
    input  logic             i_s_v,
    input  logic             i_s_d,
    output logic             o_s_r,
    output logic             o_z0_v,
    output logic [N-1:0]     o_z0_d,
    input  logic             i_z0_r,
    output logic             o_z1_v,
    output logic [N-1:0]     o_z1_d,
    input  logic             i_z1_r
`ifdef CORY_DEMUX2_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
`endif
);

    // Handshake: a stream transfers on a cycle where its valid and ready are
    // both high. Data and select transfer together or not at all; readiness
    // depends only on the valids, the select and registered buffer state.

    sel_e sel;
    logic full0, full1, empty0, empty1;
    logic tgt_full, accept, push0, push1, pop0, pop1;

    assign sel = sel_e'(i_s_d);

    always_comb begin
        tgt_full = (sel == SEL_Z1) ? full1 : full0;
        o_a_r    = i_s_v && !tgt_full;
        o_s_r    = i_a_v && !tgt_full;
        accept   = i_a_v && i_s_v && !tgt_full;
        push0    = accept && (sel == SEL_Z0);
        push1    = accept && (sel == SEL_Z1);
        o_z0_v   = !empty0;
        o_z1_v   = !empty1;
        pop0     = o_z0_v && i_z0_r;
        pop1     = o_z1_v && i_z1_r;
    end

    cory_demux2_buf #(.W(N), .Q(Q)) u_buf0 (
        .clk    (clk),
        .reset  (reset),
        .push   (push0),
        .push_d (i_a_d),
        .pop    (pop0),
        .full   (full0),
        .empty  (empty0),
        .head_d (o_z0_d)
    );

    cory_demux2_buf #(.W(N), .Q(Q)) u_buf1 (
        .clk    (clk),
        .reset  (reset),
        .push   (push1),
        .push_d (i_a_d),
        .pop    (pop1),
        .full   (full1),
        .empty  (empty1),
        .head_d (o_z1_d)
    );

`ifdef CORY_DEMUX2_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q + (push0 ? CNT_W'(1) : CNT_W'(0));
        cnt1_d = cnt1_q + (push1 ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;
`endif

endmodule
